// File: rtl/red_pitaya_pll_pkg.sv
// Shared types and DRP helpers for the PLLE2 runtime reconfiguration block.
// Holds the FSM encoding, DRP register map and the read-modify-write merges.
package red_pitaya_pll_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HOLD,
      ST_RD,
      ST_RD_W,
      ST_WR,
      ST_WR_W,
      ST_RELEASE,
      ST_WAIT_LOCK,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      ERR_OK   = 2'd0,
      ERR_DRDY = 2'd1,
      ERR_LOCK = 2'd2,
      ERR_SEL  = 2'd3
   } err_e;

   typedef struct packed {
      logic [2:0] sel;
      logic [5:0] high;
      logic [5:0] low;
      logic [2:0] phmux;
      logic [5:0] delay;
      logic       edg;
      logic       nocnt;
   } cfg_t;

   localparam logic [6:0]  CLKOUT0_ADDR = 7'h08;
   localparam logic [6:0]  CLKFB_ADDR   = 7'h14;
   localparam logic [15:0] REG1_KEEP    = 16'h1000;
   localparam logic [15:0] REG2_KEEP    = 16'hFF00;

   // Register pairs start on even addresses, so reg2 is just bit 0.
   function automatic logic [6:0] drp_addr_f(
      input logic [2:0] sel,
      input logic       reg2,
      input logic       fb
   );
      logic [6:0] base;
      base = fb ? CLKFB_ADDR : CLKOUT0_ADDR + {3'd0, sel, 1'b0};
      return base | {6'd0, reg2};
   endfunction

   function automatic logic [15:0] reg1_f(
      input cfg_t        c,
      input logic [15:0] rd
   );
      logic [15:0] f;
      f = {c.phmux, 1'b0, c.high, c.low};
      return (rd & REG1_KEEP) | (f & ~REG1_KEEP);
   endfunction

   function automatic logic [15:0] reg2_f(
      input cfg_t        c,
      input logic [15:0] rd
   );
      logic [15:0] f;
      f = {8'd0, c.edg, c.nocnt, c.delay};
      return (rd & REG2_KEEP) | (f & ~REG2_KEEP);
   endfunction

endpackage

// File: rtl/red_pitaya_pll_lock_mon.sv
// PLL lock monitor: synchronises LOCKED, flags falling edges while not gated,
// and keeps a sticky flag plus a saturating loss counter.
module red_pitaya_pll_lock_mon #(
   parameter int LCNT_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              locked_i,
   input  logic              gate_i,
   input  logic              clr_i,
   output logic              locked_o,
   output logic              lost_o,
   output logic [LCNT_W-1:0] cnt_o
);

   logic [2:0]        sync_q;
   logic              lost_q, lost_d;
   logic [LCNT_W-1:0] cnt_q, cnt_d;
   logic              fall;

   assign fall     = sync_q[2] & ~sync_q[1];
   assign locked_o = sync_q[1];
   assign lost_o   = lost_q;
   assign cnt_o    = cnt_q;

   // A clear in the same cycle as a loss event drops the event.
   always_comb begin
      lost_d = lost_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         lost_d = 1'b0;
         cnt_d  = '0;
      end else if (fall && !gate_i) begin
         lost_d = 1'b1;
         if (cnt_q != '1) cnt_d = cnt_q + LCNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         lost_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[1:0], locked_i};
         lost_q <= lost_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/red_pitaya_pll_drp.sv
// PLLE2_ADV runtime reconfiguration: holds PLL in reset, read-modify-writes
// the two DRP clock registers of one output, releases and waits for lock.
module red_pitaya_pll_drp
   import red_pitaya_pll_pkg::*;
#(
   parameter int NUM_OUT      = 6,
   parameter int RST_HOLD     = 16,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LCNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_sel,
   input  logic [5:0]        cfg_high,
   input  logic [5:0]        cfg_low,
   input  logic [2:0]        cfg_phmux,
   input  logic [5:0]        cfg_delay,
   input  logic              cfg_edge,
   input  logic              cfg_nocnt,
   output logic [6:0]        drp_addr,
   output logic [15:0]       drp_di,
   output logic              drp_en,
   output logic              drp_we,
   input  logic [15:0]       drp_do,
   input  logic              drp_rdy,
   input  logic              pll_locked,
   output logic              pll_rst,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err,
   output logic              lock_lost,
   output logic [LCNT_W-1:0] lock_cnt,
   input  logic              mon_clr
);

   localparam int MAXT_A = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
   localparam int MAXT   = (MAXT_A > DRDY_TIMEOUT) ? MAXT_A : DRDY_TIMEOUT;
   localparam int CW     = $clog2(MAXT + 1);

   localparam logic [CW-1:0] HOLD_END = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] LOCK_END = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] DRDY_END = CW'(DRDY_TIMEOUT - 1);
   localparam logic [2:0]    FB_SEL   = 3'(NUM_OUT);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   cfg_t          cfg_q, cfg_d;
   logic          reg2_q, reg2_d;
   err_e          err_q, err_d;
   logic [6:0]    addr_q, addr_d;
   logic [15:0]   di_q, di_d;
   logic          en_q, en_d;
   logic          we_q, we_d;
   logic          pll_rst_q, pll_rst_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          locked_s;
   logic          is_fb;

   assign is_fb     = (cfg_q.sel == FB_SEL);
   assign cfg_ready = (state_q == ST_IDLE);
   assign drp_addr  = addr_q;
   assign drp_di    = di_q;
   assign drp_en    = en_q;
   assign drp_we    = we_q;
   assign pll_rst   = pll_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      cfg_d   = cfg_q;
      reg2_d  = reg2_q;
      err_d   = err_q;
      addr_d  = addr_q;
      di_d    = di_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (cfg_valid) begin
               cfg_d.sel   = cfg_sel;
               cfg_d.high  = cfg_high;
               cfg_d.low   = cfg_low;
               cfg_d.phmux = cfg_phmux;
               cfg_d.delay = cfg_delay;
               cfg_d.edg   = cfg_edge;
               cfg_d.nocnt = cfg_nocnt;
               reg2_d      = 1'b0;
               if (cfg_sel > FB_SEL) begin
                  err_d   = ERR_SEL;
                  state_d = ST_DONE;
               end else begin
                  err_d   = ERR_OK;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_END) begin
               state_d = ST_RD;
               addr_d  = drp_addr_f(cfg_q.sel, reg2_q, is_fb);
            end
         end
         ST_RD: begin
            state_d = ST_RD_W;
            cnt_d   = '0;
         end
         ST_RD_W: begin
            if (drp_rdy) begin
               state_d = ST_WR;
               di_d    = reg2_q ? reg2_f(cfg_q, drp_do)
                                : reg1_f(cfg_q, drp_do);
            end else if (cnt_q == DRDY_END) begin
               err_d   = ERR_DRDY;
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end
         end
         ST_WR: begin
            state_d = ST_WR_W;
            cnt_d   = '0;
         end
         ST_WR_W: begin
            if (drp_rdy) begin
               cnt_d = '0;
               if (reg2_q) begin
                  state_d = ST_RELEASE;
               end else begin
                  reg2_d  = 1'b1;
                  state_d = ST_RD;
                  addr_d  = drp_addr_f(cfg_q.sel, 1'b1, is_fb);
               end
            end else if (cnt_q == DRDY_END) begin
               err_d   = ERR_DRDY;
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end
         end
         // The release cycle counts toward the lock timeout.
         ST_RELEASE: begin
            state_d = (err_q == ERR_DRDY) ? ST_DONE : ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = ST_DONE;
            end else if (cnt_q == LOCK_END) begin
               err_d   = ERR_LOCK;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      en_d      = (state_d == ST_RD) || (state_d == ST_WR);
      we_d      = (state_d == ST_WR);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
      pll_rst_d = state_d inside {ST_HOLD, ST_RD, ST_RD_W, ST_WR, ST_WR_W};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_WAIT_LOCK;
         cnt_q     <= '0;
         cfg_q     <= '0;
         reg2_q    <= 1'b0;
         err_q     <= ERR_OK;
         addr_q    <= '0;
         di_q      <= '0;
         en_q      <= 1'b0;
         we_q      <= 1'b0;
         pll_rst_q <= 1'b1;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cfg_q     <= cfg_d;
         reg2_q    <= reg2_d;
         err_q     <= err_d;
         addr_q    <= addr_d;
         di_q      <= di_d;
         en_q      <= en_d;
         we_q      <= we_d;
         pll_rst_q <= pll_rst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   red_pitaya_pll_lock_mon #(
      .LCNT_W(LCNT_W)
   ) u_lock_mon (
      .clk_i   (clk),
      .rst_i   (rst),
      .locked_i(pll_locked),
      .gate_i  (busy_q),
      .clr_i   (mon_clr),
      .locked_o(locked_s),
      .lost_o  (lock_lost),
      .cnt_o   (lock_cnt)
   );

endmodule
